extmemarb: RTL and testbench
============================

EXTMEMARB -- requirements
Module: extmemarb

Interface
REQ-001 SHALL have parameter: STARVE, 4, consecutive CPU grants tolerated while ARM waits (used only with EXTMEMARB_FAIR_EN; legal 1..15).
REQ-002 SHALL have port: CLOCK  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: RESET_N  input  1  synchronous active-low reset.
REQ-004 SHALL have ports: c_req input 1, c_wena input 1, c_addr input 15, c_wdat input 12 -- CPU-side access request, write flag, word address, write data.
REQ-005 SHALL have ports: c_ack output 1, c_rdat output 12 -- CPU-side one-cycle completion pulse, registered read data.
REQ-006 SHALL have ports: a_req, a_wena, a_addr[14:00], a_wdat[11:00] inputs; a_ack, a_rdat[11:00] outputs -- same meanings for the ARM-side requester (AXI mapper).
REQ-007 SHALL have ports: xbraddr output 15, xbrwdat output 12, xbrrdat input 12, xbrenab output 1, xbrwena output 1 -- single-port extended-memory block RAM.
REQ-008 SHALL have port: owner output 1 -- 0 CPU, 1 ARM; requester of the current or last access.

Function
REQ-009 SHALL use a four-state machine IDLE -> ACC1 -> ACC2 -> DONE -> IDLE; each non-IDLE state lasts exactly one cycle.
REQ-010 SHALL, in IDLE with at least one req high, grant one requester, latch its addr/wena/wdat into registers, set owner, and enter ACC1.
REQ-011 SHALL drive xbraddr, xbrwdat, xbrwena from the latched registers only; requester inputs never reach the RAM combinationally.
REQ-012 SHALL hold xbrenab=1 in ACC1 and ACC2 and 0 in IDLE and DONE; xbrwena=1 in ACC1/ACC2 only for writes.
REQ-013 SHALL, on the ACC2->DONE edge, capture xbrrdat into the owner's rdat register (reads only); the other requester's rdat is unchanged, and on writes the owner's rdat is unchanged.
REQ-014 SHALL assert the owner's ack for exactly the DONE cycle; latency from grant edge to ack high is 3 cycles, minimum spacing between grants 4 cycles.
REQ-015 SHALL ignore all req inputs outside IDLE; a requester holds req and its operands stable until ack and drops req in the cycle after ack, else a new access is started.
REQ-016 SHALL, with both req high in IDLE, grant CPU unless the fairness rule (REQ-022) selects ARM.
REQ-017 SHALL treat addr, wdat and wena as don't-care while req is low.
REQ-018 SHALL never assert c_ack and a_ack in the same cycle.

Reset
REQ-019 SHALL, while RESET_N=0 at a clock edge, enter IDLE and clear xbrenab, xbrwena, c_ack, a_ack, owner, c_rdat, a_rdat, latched address/data and the starvation counter.
REQ-020 SHALL abandon an access in progress when reset occurs in ACC1, ACC2 or DONE: no ack issued, no rdat update after reset.
REQ-021 SHALL accept a new request in the first cycle after RESET_N returns high.

Configuration
REQ-022 SHALL, with EXTMEMARB_FAIR_EN defined, keep a 4-bit counter incremented on each CPU grant made while a_req is high, cleared on ARM grant or whenever in IDLE with a_req low; when counter equals STARVE and both req are high in IDLE, ARM is granted.
REQ-023 SHALL, without EXTMEMARB_FAIR_EN, use strict CPU priority, contain no counter, and ignore STARVE.

Verification
REQ-024 SHALL verify: CPU read addr 15'o12345, RAM word 12'o7070 -> xbrenab high 2 cycles, c_ack 3 cycles after grant, c_rdat=12'o7070, a_ack never high.
REQ-025 SHALL verify: ARM write addr 15'o00017 data 12'o4321 then CPU read same addr -> xbrwena high 2 cycles, a_rdat unchanged, CPU reads 12'o4321.
REQ-026 SHALL verify: c_req and a_req rise same cycle -> CPU granted first (owner=0), ARM granted at the next IDLE, 4 cycles later (owner=1).
REQ-027 SHALL verify with EXTMEMARB_FAIR_EN, STARVE=4, c_req and a_req held high continuously -> grant sequence C,C,C,C,A repeating; without macro -> ARM never granted.
REQ-028 SHALL verify: RESET_N low for 1 cycle during ACC2 of a CPU read -> no c_ack, c_rdat=0, xbrenab=0 next cycle, new a_req granted the cycle after reset releases.

Source files
------------

// File: rtl/extmemarb_if.sv
// Bundle of the CPU/ARM requester handshakes and the extended-memory RAM port.
// slave: the arbiter's view. master: requesters plus RAM, as seen from outside.
interface extmemarb_if;
  logic        c_req;
  logic        c_wena;
  logic [14:0] c_addr;
  logic [11:0] c_wdat;
  logic        c_ack;
  logic [11:0] c_rdat;

  logic        a_req;
  logic        a_wena;
  logic [14:0] a_addr;
  logic [11:0] a_wdat;
  logic        a_ack;
  logic [11:0] a_rdat;

  logic [14:0] xbraddr;
  logic [11:0] xbrwdat;
  logic [11:0] xbrrdat;
  logic        xbrenab;
  logic        xbrwena;
  logic        owner;

  modport slave (
    input  c_req, c_wena, c_addr, c_wdat, a_req, a_wena, a_addr, a_wdat, xbrrdat,
    output c_ack, c_rdat, a_ack, a_rdat, xbraddr, xbrwdat, xbrenab, xbrwena, owner
  );

  modport master (
    output c_req, c_wena, c_addr, c_wdat, a_req, a_wena, a_addr, a_wdat, xbrrdat,
    input  c_ack, c_rdat, a_ack, a_rdat, xbraddr, xbrwdat, xbrenab, xbrwena, owner
  );
endinterface

// File: rtl/extmemarb.sv
// Two-requester (CPU/ARM) arbiter for a single-port extended-memory block RAM.
// Define EXTMEMARB_FAIR_EN to let ARM win after STARVE consecutive CPU grants.
module extmemarb #(
  parameter int unsigned STARVE = 4
) (
  input logic        CLOCK,
  input logic        RESET_N,
  extmemarb_if.slave mem_if
);

  typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StDone} state_e;

  state_e      state_q;
  logic        owner_q;
  logic        enab_q;
  logic        wena_q;
  logic        c_ack_q;
  logic        a_ack_q;
  logic [14:0] addr_q;
  logic [11:0] wdat_q;
  logic [11:0] c_rdat_q;
  logic [11:0] a_rdat_q;
  logic        pick_arm;

  if (STARVE < 1 || STARVE > 15) begin : g_starve_range
    $error("extmemarb: STARVE must be in 1..15");
  end

`ifdef EXTMEMARB_FAIR_EN
  logic [3:0] starve_q;

  always_comb pick_arm = mem_if.a_req && (!mem_if.c_req || (starve_q == 4'(STARVE)));

  // Counts CPU wins while ARM is kept waiting; only updated on IDLE decisions.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      starve_q <= 4'd0;
    end else if (state_q == StIdle) begin
      if (!mem_if.a_req || pick_arm) begin
        starve_q <= 4'd0;
      end else if (mem_if.c_req) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end
`else
  always_comb pick_arm = mem_if.a_req && !mem_if.c_req;
`endif

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      enab_q   <= 1'b0;
      wena_q   <= 1'b0;
      c_ack_q  <= 1'b0;
      a_ack_q  <= 1'b0;
      addr_q   <= 15'd0;
      wdat_q   <= 12'd0;
      c_rdat_q <= 12'd0;
      a_rdat_q <= 12'd0;
    end else begin
      c_ack_q <= 1'b0;
      a_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_if.c_req || mem_if.a_req) begin
            owner_q <= pick_arm;
            addr_q  <= pick_arm ? mem_if.a_addr : mem_if.c_addr;
            wdat_q  <= pick_arm ? mem_if.a_wdat : mem_if.c_wdat;
            wena_q  <= pick_arm ? mem_if.a_wena : mem_if.c_wena;
            enab_q  <= 1'b1;
            state_q <= StAcc1;
          end
        end
        StAcc1: state_q <= StAcc2;
        StAcc2: begin
          // RAM output registered at the ACC1->ACC2 edge is valid now.
          if (!wena_q) begin
            if (owner_q) a_rdat_q <= mem_if.xbrrdat;
            else         c_rdat_q <= mem_if.xbrrdat;
          end
          if (owner_q) a_ack_q <= 1'b1;
          else         c_ack_q <= 1'b1;
          enab_q  <= 1'b0;
          wena_q  <= 1'b0;
          state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_if.xbraddr = addr_q;
  assign mem_if.xbrwdat = wdat_q;
  assign mem_if.xbrenab = enab_q;
  assign mem_if.xbrwena = wena_q;
  assign mem_if.owner   = owner_q;
  assign mem_if.c_ack   = c_ack_q;
  assign mem_if.a_ack   = a_ack_q;
  assign mem_if.c_rdat  = c_rdat_q;
  assign mem_if.a_rdat  = a_rdat_q;

endmodule

// File: tb/tb_extmemarb.sv
// Directed bench for extmemarb: CPU/ARM reads and writes, contention,
// fairness (or strict priority) and reset during an access.
module tb_extmemarb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   dual_ack = 0;

  logic [11:0] mem [0:32767];

  extmemarb_if bus ();

  extmemarb #(.STARVE(4)) dut (
    .CLOCK  (clk),
    .RESET_N(rst_n),
    .mem_if (bus)
  );

  always #5 clk = ~clk;

  // Synchronous single-port block RAM model.
  always @(posedge clk) begin
    if (bus.xbrenab) begin
      if (bus.xbrwena) mem[bus.xbraddr] <= bus.xbrwdat;
      else             bus.xbrrdat <= mem[bus.xbraddr];
    end
  end

  always @(negedge clk) begin
    if (bus.c_ack && bus.a_ack) dual_ack++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] en_pat;
  logic [3:0] ack_pat;
  logic [9:0] own_pat;

  initial begin
    bus.c_req = 1'b0; bus.c_wena = 1'b0; bus.c_addr = '0; bus.c_wdat = '0;
    bus.a_req = 1'b0; bus.a_wena = 1'b0; bus.a_addr = '0; bus.a_wdat = '0;
    mem[15'o12345] <= 12'o7070;
    en_pat  = 4'b0011;
    ack_pat = 4'b0100;

    // Reset state
    repeat (3) tick();
    chk("rst_owner", bus.owner, 0);
    chk("rst_cack", bus.c_ack, 0);
    chk("rst_aack", bus.a_ack, 0);
    chk("rst_enab", bus.xbrenab, 0);
    chk("rst_wena", bus.xbrwena, 0);
    chk("rst_crdat", bus.c_rdat, 0);
    chk("rst_ardat", bus.a_rdat, 0);
    rst_n = 1'b1;

    // CPU read of 15'o12345
    bus.c_req = 1'b1; bus.c_wena = 1'b0; bus.c_addr = 15'o12345;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_enab", bus.xbrenab, en_pat[i]);
      chk("t1_cack", bus.c_ack, ack_pat[i]);
      chk("t1_aack", bus.a_ack, 0);
      if (i == 2) bus.c_req = 1'b0;
    end
    chk("t1_crdat", bus.c_rdat, 12'o7070);
    chk("t1_owner", bus.owner, 0);

    // ARM write then CPU read of the same word
    bus.a_req = 1'b1; bus.a_wena = 1'b1; bus.a_addr = 15'o00017; bus.a_wdat = 12'o4321;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_wena", bus.xbrwena, en_pat[i]);
      chk("t2_aack", bus.a_ack, ack_pat[i]);
      if (i == 0) chk("t2_owner", bus.owner, 1);
      if (i == 0) chk("t2_wdat", bus.xbrwdat, 12'o4321);
      if (i == 2) bus.a_req = 1'b0;
    end
    chk("t2_ardat", bus.a_rdat, 0);
    bus.c_req = 1'b1; bus.c_wena = 1'b0; bus.c_addr = 15'o00017;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2r_cack", bus.c_ack, ack_pat[i]);
      if (i == 2) bus.c_req = 1'b0;
    end
    chk("t2r_crdat", bus.c_rdat, 12'o4321);
    chk("t2r_ardat", bus.a_rdat, 0);

    // Simultaneous requests: CPU first, ARM four cycles later
    bus.c_req = 1'b1; bus.c_wena = 1'b0; bus.c_addr = 15'o12345;
    bus.a_req = 1'b1; bus.a_wena = 1'b0; bus.a_addr = 15'o00017;
    for (int i = 0; i < 8; i++) begin
      tick();
      case (i)
        0: chk("t3_owner_c", bus.owner, 0);
        2: begin
          chk("t3_cack", bus.c_ack, 1);
          bus.c_req = 1'b0;
        end
        3: chk("t3_idle_enab", bus.xbrenab, 0);
        4: begin
          chk("t3_owner_a", bus.owner, 1);
          chk("t3_enab_a", bus.xbrenab, 1);
        end
        6: begin
          chk("t3_aack", bus.a_ack, 1);
          chk("t3_cack_lo", bus.c_ack, 0);
          bus.a_req = 1'b0;
        end
        default: ;
      endcase
    end
    chk("t3_ardat", bus.a_rdat, 12'o4321);
    chk("t3_crdat", bus.c_rdat, 12'o7070);

    // Both requests held continuously
`ifdef EXTMEMARB_FAIR_EN
    own_pat = 10'b1000010000;
`else
    own_pat = 10'b0000000000;
`endif
    bus.c_req = 1'b1; bus.a_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4_grant_owner", bus.owner, own_pat[k]);
      repeat (3) tick();
    end
    bus.c_req = 1'b0; bus.a_req = 1'b0;
    tick();
    chk("t4_idle_enab", bus.xbrenab, 0);

    // Reset during ACC2 of a CPU read, then an immediate ARM grant
    bus.c_req = 1'b1; bus.c_wena = 1'b0; bus.c_addr = 15'o12345;
    tick();
    tick();
    chk("t5_acc2_enab", bus.xbrenab, 1);
    rst_n = 1'b0;
    tick();
    chk("t5_cack", bus.c_ack, 0);
    chk("t5_crdat", bus.c_rdat, 0);
    chk("t5_ardat", bus.a_rdat, 0);
    chk("t5_enab", bus.xbrenab, 0);
    rst_n = 1'b1;
    bus.c_req = 1'b0;
    bus.a_req = 1'b1; bus.a_wena = 1'b0; bus.a_addr = 15'o00017;
    tick();
    chk("t5_owner_a", bus.owner, 1);
    chk("t5_enab_a", bus.xbrenab, 1);
    tick();
    chk("t5_cack_acc2", bus.c_ack, 0);
    tick();
    chk("t5_aack", bus.a_ack, 1);
    chk("t5_cack_done", bus.c_ack, 0);
    chk("t5_ardat_new", bus.a_rdat, 12'o4321);
    chk("t5_crdat_kept", bus.c_rdat, 0);
    bus.a_req = 1'b0;
    tick();

    chk("no_dual_ack", dual_ack, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
